// File: rtl/trapezoid_bank_if.sv
// Handshake bundle for trapezoid_bank: parameter write port, sample input and mu result stream.
// The master side drives configuration and samples; the slave side is the bank itself.
interface trapezoid_bank_if #(
    parameter int N_MF = 4,
    parameter int XW   = 8,
    parameter int MUW  = 16
);
    localparam int IW = (N_MF > 1) ? $clog2(N_MF) : 1;

    logic                 cfg_we;
    logic                 cfg_ready;
    logic [IW-1:0]        cfg_idx;
    logic signed [XW-1:0] cfg_a;
    logic signed [XW-1:0] cfg_b;
    logic signed [XW-1:0] cfg_c;
    logic signed [XW-1:0] cfg_d;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [XW-1:0] in_x;

    logic                 out_valid;
    logic                 out_ready;
    logic [IW-1:0]        out_idx;
    logic [MUW-1:0]       out_mu;
    logic                 out_last;

    modport master (
        output cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d,
        output in_valid, in_x, out_ready,
        input  cfg_ready, in_ready, out_valid, out_idx, out_mu, out_last
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d,
        input  in_valid, in_x, out_ready,
        output cfg_ready, in_ready, out_valid, out_idx, out_mu, out_last
    );
endinterface

// File: rtl/trapezoid_bank.sv
// Sequential bank of trapezoid membership functions sharing one restoring divider.
// Each MF is classified, optionally divided one quotient bit per cycle, then streamed out in index order.
module trapezoid_bank #(
    parameter int N_MF = 4,
    parameter int XW   = 8,
    parameter int MUW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    trapezoid_bank_if.slave bus
);
    localparam int IW = (N_MF > 1) ? $clog2(N_MF) : 1;
    localparam int QW = MUW - 1;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [MUW-1:0] MU_FULL  = {1'b0, {QW{1'b1}}};
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_MF - 1);

    typedef enum logic [1:0] {IDLE, CLASS, DIV, OUT} state_t;

    state_t               state_reg;
    logic signed [XW-1:0] x_reg;
    logic [IW-1:0]        idx_reg;
    logic [XW+1:0]        rem_reg;
    logic [XW:0]          den_reg;
    logic [QW-1:0]        quo_reg;
    logic [CW-1:0]        iter_reg;
    logic                 sat_reg;
    logic                 in_ready_reg;
    logic                 cfg_ready_reg;
    logic                 out_valid_reg;
    logic [IW-1:0]        out_idx_reg;
    logic [MUW-1:0]       out_mu_reg;
    logic                 out_last_reg;

    logic signed [XW-1:0] a_arr [N_MF];
    logic signed [XW-1:0] b_arr [N_MF];
    logic signed [XW-1:0] c_arr [N_MF];
    logic signed [XW-1:0] d_arr [N_MF];

    logic cfg_accept;
    assign cfg_accept = bus.cfg_we & cfg_ready_reg;

    // Parameters live in plain registers so reset can clear every MF in one edge.
    generate
        for (genvar gi = 0; gi < N_MF; gi++) begin : g_param
            logic signed [XW-1:0] a_reg, b_reg, c_reg, d_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                    c_reg <= '0;
                    d_reg <= '0;
                end else if (cfg_accept && bus.cfg_idx == IW'(gi)) begin
                    a_reg <= bus.cfg_a;
                    b_reg <= bus.cfg_b;
                    c_reg <= bus.cfg_c;
                    d_reg <= bus.cfg_d;
                end
            end

            assign a_arr[gi] = a_reg;
            assign b_arr[gi] = b_reg;
            assign c_arr[gi] = c_reg;
            assign d_arr[gi] = d_reg;
        end
    endgenerate

    logic signed [XW-1:0] a_rd, b_rd, c_rd, d_rd;
    assign a_rd = a_arr[idx_reg];
    assign b_rd = b_arr[idx_reg];
    assign c_rd = c_arr[idx_reg];
    assign d_rd = d_arr[idx_reg];

    logic in_outside, in_plateau, on_left;
    assign in_outside = (x_reg <= a_rd) || (x_reg >= d_rd);
    assign in_plateau = (b_rd <= x_reg) && (x_reg <= c_rd);
    assign on_left    = (x_reg < b_rd);

    // One extra bit keeps the full span of two signed XW-bit values positive.
    logic [XW:0] x_ext, a_ext, b_ext, c_ext, d_ext;
    logic [XW:0] num_sel, den_sel;
    assign x_ext   = {x_reg[XW-1], x_reg};
    assign a_ext   = {a_rd[XW-1], a_rd};
    assign b_ext   = {b_rd[XW-1], b_rd};
    assign c_ext   = {c_rd[XW-1], c_rd};
    assign d_ext   = {d_rd[XW-1], d_rd};
    assign num_sel = on_left ? (x_ext - a_ext) : (d_ext - x_ext);
    assign den_sel = on_left ? (b_ext - a_ext) : (d_ext - c_ext);

    logic [XW+1:0] rem_shift, rem_next, den_wide;
    logic          q_bit;
    logic [QW-1:0] quo_next;
    assign rem_shift = {rem_reg[XW:0], 1'b0};
    assign den_wide  = {1'b0, den_reg};
    assign q_bit     = (rem_shift >= den_wide);
    assign rem_next  = q_bit ? (rem_shift - den_wide) : rem_shift;
    assign quo_next  = QW'({quo_reg, q_bit});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            idx_reg       <= '0;
            rem_reg       <= '0;
            den_reg       <= '0;
            quo_reg       <= '0;
            iter_reg      <= '0;
            sat_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            cfg_ready_reg <= 1'b1;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_mu_reg    <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg         <= bus.in_x;
                        idx_reg       <= '0;
                        in_ready_reg  <= 1'b0;
                        cfg_ready_reg <= 1'b0;
                        state_reg     <= CLASS;
                    end
                end
                CLASS: begin
                    if (in_outside || in_plateau) begin
                        out_mu_reg    <= in_outside ? '0 : MU_FULL;
                        out_idx_reg   <= idx_reg;
                        out_last_reg  <= (idx_reg == LAST_IDX);
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end else begin
                        rem_reg   <= {1'b0, num_sel};
                        den_reg   <= (den_sel == '0) ? (XW+1)'(1) : den_sel;
                        sat_reg   <= (den_sel == '0);
                        quo_reg   <= '0;
                        iter_reg  <= '0;
                        state_reg <= DIV;
                    end
                end
                DIV: begin
                    rem_reg  <= rem_next;
                    quo_reg  <= quo_next;
                    iter_reg <= iter_reg + CW'(1);
                    if (iter_reg == CW'(QW - 1)) begin
                        out_mu_reg    <= sat_reg ? MU_FULL : {1'b0, quo_next};
                        out_idx_reg   <= idx_reg;
                        out_last_reg  <= (idx_reg == LAST_IDX);
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            in_ready_reg  <= 1'b1;
                            cfg_ready_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            state_reg <= CLASS;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.cfg_ready = cfg_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_mu    = out_mu_reg;
    assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_trapezoid_bank.sv
// Randomized and directed bench for trapezoid_bank against a plain-arithmetic membership model.
`timescale 1ns/1ps
module tb_trapezoid_bank;
    localparam int N_MF = 4;
    localparam int XW   = 8;
    localparam int MUW  = 16;
    localparam int IW   = 2;
    localparam int FULL = (1 << (MUW - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trapezoid_bank_if #(.N_MF(N_MF), .XW(XW), .MUW(MUW)) bus ();

    trapezoid_bank #(.N_MF(N_MF), .XW(XW), .MUW(MUW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ma [N_MF];
    int mb [N_MF];
    int mc [N_MF];
    int md [N_MF];
    logic [MUW-1:0] res_mu [N_MF];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Membership from the trapezoid definition: linear ramp scaled to Q1.(MUW-1), truncated.
    function automatic int mu_ref(int x, int a, int b, int c, int d);
        if (x <= a || x >= d) return 0;
        if (b <= x && x <= c) return FULL;
        if (x < b) return ((x - a) * (1 << (MUW - 1))) / (b - a);
        return ((d - x) * (1 << (MUW - 1))) / (d - c);
    endfunction

    function automatic int lat_ref(int x, int a, int b, int c, int d);
        if (x <= a || x >= d) return 2;
        if (b <= x && x <= c) return 2;
        return MUW + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_MF; i++) begin
            ma[i] = 0; mb[i] = 0; mc[i] = 0; md[i] = 0;
        end
    endtask

    task automatic cfg_write(input int idx, input int a, input int b, input int c, input int d);
        int guard;
        guard = 0;
        while (!bus.cfg_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = idx[IW-1:0];
        bus.cfg_a   = a[XW-1:0];
        bus.cfg_b   = b[XW-1:0];
        bus.cfg_c   = c[XW-1:0];
        bus.cfg_d   = d[XW-1:0];
        @(negedge clk);
        bus.cfg_we = 1'b0;
        ma[idx] = a; mb[idx] = b; mc[idx] = c; md[idx] = d;
        $display("cfg idx=%0d a=%0d b=%0d c=%0d d=%0d", idx, a, b, c, d);
    endtask

    task automatic run_frame(input int x, input int bp_k, input int bp_len,
                             input bit inject, input int abort_k);
        int lat;
        int guard;
        int exp_mu;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_x     = x[XW-1:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        chk("cfg_ready_busy", bus.cfg_ready, 0);
        chk("in_ready_busy", bus.in_ready, 0);
        if (inject) begin
            bus.cfg_we  = 1'b1;
            bus.cfg_idx = '0;
            bus.cfg_a   = '0;
            bus.cfg_b   = '0;
            bus.cfg_c   = '0;
            bus.cfg_d   = '0;
        end
        for (int k = 0; k < N_MF; k++) begin
            if (k == abort_k) begin
                repeat (4) @(negedge clk);
                bus.cfg_we = 1'b0;
                chk("abort_pre_valid", bus.out_valid, 0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_in_ready", bus.in_ready, 1);
                chk("abort_cfg_ready", bus.cfg_ready, 1);
                chk("abort_out_valid", bus.out_valid, 0);
                chk("abort_out_mu", bus.out_mu, 0);
                chk("abort_out_idx", bus.out_idx, 0);
                model_clear();
                $display("frame x=%0d reset during idx=%0d", x, k);
                return;
            end
            while (!bus.out_valid && lat < MUW + 8) begin
                @(negedge clk);
                bus.cfg_we = 1'b0;
                lat++;
            end
            exp_mu = mu_ref(x, ma[k], mb[k], mc[k], md[k]);
            chk("latency", lat, lat_ref(x, ma[k], mb[k], mc[k], md[k]));
            if (!bus.out_valid) return;
            chk("out_idx", bus.out_idx, k);
            chk("out_mu", bus.out_mu, exp_mu);
            chk("out_last", bus.out_last, (k == N_MF - 1));
            res_mu[k] = bus.out_mu;
            $display("frame x=%0d idx=%0d mu=%04h lat=%0d", x, k, bus.out_mu, lat);
            if (k == bp_k) begin
                bus.out_ready = 1'b0;
                for (int i = 0; i < bp_len; i++) begin
                    @(negedge clk);
                    chk("bp_valid", bus.out_valid, 1);
                    chk("bp_mu", bus.out_mu, exp_mu);
                    chk("bp_idx", bus.out_idx, k);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            bus.cfg_we = 1'b0;
            lat = 1;
        end
        chk("end_out_valid", bus.out_valid, 0);
        chk("end_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int v [4];
        int t;
        int x;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        bus.cfg_c     = '0;
        bus.cfg_d     = '0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_mu", bus.out_mu, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);

        run_frame(0, -1, 0, 1'b0, -1);
        for (int i = 0; i < N_MF; i++) chk("rst_frame_mu", res_mu[i], 0);

        cfg_write(0, -40, -20, 20, 40);
        cfg_write(1, 0, 10, 10, 20);
        cfg_write(2, -100, -50, -50, 0);
        cfg_write(3, 50, 60, 100, 120);

        run_frame(-30, -1, 0, 1'b0, -1);
        chk("mf0_xm30", res_mu[0], 16'h4000);
        run_frame(0, -1, 0, 1'b0, -1);
        chk("mf0_x0", res_mu[0], 16'h7FFF);
        run_frame(30, -1, 0, 1'b0, -1);
        chk("mf0_x30", res_mu[0], 16'h4000);
        run_frame(-40, -1, 0, 1'b0, -1);
        chk("mf0_xm40", res_mu[0], 16'h0000);
        run_frame(40, 1, 5, 1'b0, -1);
        chk("mf0_x40", res_mu[0], 16'h0000);
        run_frame(10, -1, 0, 1'b0, -1);
        chk("mf1_x10", res_mu[1], 16'h7FFF);
        run_frame(3, 1, 5, 1'b0, -1);
        chk("mf1_x3", res_mu[1], 16'h2666);
        run_frame(17, -1, 0, 1'b0, -1);
        chk("mf1_x17", res_mu[1], 16'h2666);

        // A busy-time write must not disturb MF0.
        run_frame(-30, -1, 0, 1'b1, -1);
        run_frame(-30, -1, 0, 1'b0, -1);
        chk("gated_cfg_mf0", res_mu[0], 16'h4000);
        cfg_write(0, -60, -40, 40, 60);
        run_frame(-30, -1, 0, 1'b0, -1);
        chk("idle_cfg_mf0", res_mu[0], 16'h7FFF);

        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
                if ($urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (v[j] > v[j+1]) begin
                                t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                            end
                end
                cfg_write(int'($urandom_range(0, N_MF - 1)), v[0], v[1], v[2], v[3]);
            end
            t = int'($urandom_range(0, N_MF - 1));
            if ($urandom_range(0, 1) == 1)
                x = (t == 0) ? ma[0] : (t == 1) ? mb[1] : (t == 2) ? mc[2] : md[3];
            else
                x = int'($urandom_range(0, 255)) - 128;
            run_frame(x, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N_MF - 1)) : -1,
                      int'($urandom_range(1, 6)), 1'b0, -1);
        end

        cfg_write(2, -100, -50, -50, 0);
        run_frame(-30, -1, 0, 1'b0, 2);
        run_frame(-30, -1, 0, 1'b0, -1);
        for (int i = 0; i < N_MF; i++) chk("post_abort_mu", res_mu[i], 0);
        run_frame(0, -1, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
